// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding and default depth.
package fetch_queue_pkg;

   // Default number of queue entries (power of two, 2..16).
   localparam int unsigned FQ_DEPTH_DEFAULT = 4;

   // RUN issues fetches normally; DRAIN swallows responses to fetches
   // that were in flight when a redirect arrived.
   typedef enum logic {
      FQ_RUN   = 1'b0,
      FQ_DRAIN = 1'b1
   } fq_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's PC, memory and decode-side signals.
//
// Handshakes: a memory request transfers in a cycle where MemReq and MemGnt
// are both high (PCAdvance mirrors that transfer); a response transfers in
// any cycle where MemRvalid is high, one per granted request, in order; the
// head instruction transfers in a cycle where InstrValid and InstrReady are
// both high. MemReq and InstrValid never depend on MemGnt or InstrReady.
interface fetch_queue_if;
   logic [31:0] PCResult;
   logic        PCAdvance;
   logic [31:0] MemAddr;
   logic        MemReq;
   logic        MemGnt;
   logic [31:0] MemRdata;
   logic        MemRvalid;
   logic        Flush;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;

   // The fetch queue itself.
   modport master (
      input  PCResult, MemGnt, MemRdata, MemRvalid, Flush, InstrReady,
      output PCAdvance, MemAddr, MemReq, InstrOut, InstrPC, InstrValid
   );

   // The surrounding pipeline: PC register, instruction memory, decode.
   modport slave (
      output PCResult, MemGnt, MemRdata, MemRvalid, Flush, InstrReady,
      input  PCAdvance, MemAddr, MemReq, InstrOut, InstrPC, InstrValid
   );
endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x 64 bits, {pc, instr}; separate write ports for each
// half so a grant and a response can land in the same cycle, async read.
module fetch_queue_ram
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          pc_we,
   input  logic [AW-1:0] pc_waddr,
   input  logic [31:0]   pc_wdata,
   input  logic          d_we,
   input  logic [AW-1:0] d_waddr,
   input  logic [31:0]   d_wdata,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [63:0] mem_q [DEPTH];

   // Write PC half on grant and instruction half on response; contents are never reset.
   always_ff @(posedge clk) begin
      if (pc_we) mem_q[pc_waddr][63:32] <= pc_wdata;
      if (d_we)  mem_q[d_waddr][31:0]   <= d_wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC requests to memory, buffers returned
// words in order, and drains stale responses after a redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
   input  logic          Clk,
   input  logic          Reset,
   fetch_queue_if.master bus,
   output fq_state_e     state_dbg
);

   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam int unsigned   PW      = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   // head: next to decode; fill: next to receive data; tail: next to allocate.
   fq_state_e     state_q, state_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] fill_q, fill_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] disc_q, disc_d;

   logic [PW-1:0] occ;
   logic [PW-1:0] in_flight;
   logic [PW-1:0] flush_base;
   logic          mem_req;
   logic          grant;
   logic          rsp_take;
   logic          instr_valid;
   logic          pop;
   logic [63:0]   head_entry;

   // Handshake qualifiers; a stray response (nothing in flight) is ignored.
   always_comb begin
      occ         = tail_q - head_q;
      in_flight   = tail_q - fill_q;
      mem_req     = (state_q == FQ_RUN) && (occ < DEPTH_P) && !bus.Flush && !Reset;
      grant       = mem_req && bus.MemGnt;
      rsp_take    = bus.MemRvalid && (state_q == FQ_RUN) && !bus.Flush && (in_flight != '0);
      instr_valid = (fill_q != head_q) && !Reset;
      pop         = instr_valid && bus.InstrReady;
   end

   // Pointer, discard-counter and RUN/DRAIN next-state logic.
   always_comb begin
      head_d     = head_q;
      fill_d     = fill_q;
      tail_d     = tail_q;
      disc_d     = disc_q;
      state_d    = state_q;
      // disc_q is zero in RUN and tail==fill in DRAIN, so this sum is the
      // number of responses still owed by memory in either state.
      flush_base = disc_q + in_flight;
      if (bus.Flush) begin
         head_d  = tail_q;
         fill_d  = tail_q;
         tail_d  = tail_q;
         disc_d  = flush_base - ((bus.MemRvalid && (flush_base != '0)) ? ONE_P : '0);
         state_d = (disc_d != '0) ? FQ_DRAIN : FQ_RUN;
      end else begin
         if (grant)    tail_d = tail_q + ONE_P;
         if (rsp_take) fill_d = fill_q + ONE_P;
         if (pop)      head_d = head_q + ONE_P;
         if ((state_q == FQ_DRAIN) && bus.MemRvalid) begin
            disc_d = disc_q - ONE_P;
            if (disc_d == '0) state_d = FQ_RUN;
         end
      end
   end

   // State register; reset drops every entry immediately without draining.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= FQ_RUN;
         head_q  <= '0;
         fill_q  <= '0;
         tail_q  <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         fill_q  <= fill_d;
         tail_q  <= tail_d;
         disc_q  <= disc_d;
      end
   end

   fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk      (Clk),
      .pc_we    (grant),
      .pc_waddr (tail_q[AW-1:0]),
      .pc_wdata (bus.PCResult),
      .d_we     (rsp_take),
      .d_waddr  (fill_q[AW-1:0]),
      .d_wdata  (bus.MemRdata),
      .raddr    (head_q[AW-1:0]),
      .rdata    (head_entry)
   );

   assign bus.MemAddr    = bus.PCResult;
   assign bus.MemReq     = mem_req;
   assign bus.PCAdvance  = grant;
   assign bus.InstrValid = instr_valid;
   assign bus.InstrOut   = head_entry[31:0];
   assign bus.InstrPC    = head_entry[63:32];
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a per-cycle vector table for streaming,
// latency and same-cycle response/pop, then hand sequences for full queue,
// flush/drain and reset during drain.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   fq_state_e   state_dbg;
   logic [31:0] pc_q;
   int          n_checks = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic        g;
      logic        rv;
      logic [31:0] rd;
      logic        e_req;
      logic        e_adv;
      logic        e_iv;
      logic [31:0] e_iout;
      logic [31:0] e_ipc;
   } vec_t;
   vec_t vq[$];

   fetch_queue_if bus();

   fetch_queue #(.DEPTH(4)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock and upstream PC register (advances by 4 on each accepted fetch).
   always #5 Clk = ~Clk;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) pc_q <= '0;
      else if (bus.PCAdvance) pc_q <= pc_q + 32'd4;
   end
   assign bus.PCResult = pc_q;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic ry, input logic fl);
      bus.MemGnt     = g;
      bus.MemRvalid  = rv;
      bus.MemRdata   = rd;
      bus.InstrReady = ry;
      bus.Flush      = fl;
   endtask

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      Reset = 1'b1;
      @(negedge Clk);
      check("rst_memreq", bus.MemReq, 32'd0);
      check("rst_pcadvance", bus.PCAdvance, 32'd0);
      check("rst_instrvalid", bus.InstrValid, 32'd0);
      check("rst_state", state_dbg, FQ_RUN);
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      Reset = 1'b0;
   endtask

   task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                      input logic er, input logic ea, input logic ei,
                      input logic [31:0] eo, input logic [31:0] ep);
      vec_t v;
      v.g = g; v.rv = rv; v.rd = rd;
      v.e_req = er; v.e_adv = ea; v.e_iv = ei; v.e_iout = eo; v.e_ipc = ep;
      vq.push_back(v);
   endtask

   initial begin
      logic [63:0] e;
      // Streaming table: grant each cycle, response two cycles after grant,
      // decode always ready. Row 0 is a stray response that must be ignored.
      //   g     rv    rdata          req   adv   ivalid iout           ipc
      add(1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
      add(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
      add(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
      add(1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
      add(1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0000, 32'h0);
      add(1'b0, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b1, 32'hA000_0001, 32'h4);
      add(1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b1, 32'hA000_0002, 32'h8);
      add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA000_0003, 32'hC);
      add(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
      add(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
      add(1'b0, 1'b1, 32'hA000_0004, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
      add(1'b0, 1'b1, 32'hA000_0005, 1'b1, 1'b0, 1'b1, 32'hA000_0004, 32'h10);
      add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA000_0005, 32'h14);
      add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);

      do_reset();
      foreach (vq[i]) begin
         drive(vq[i].g, vq[i].rv, vq[i].rd, 1'b1, 1'b0);
         @(negedge Clk);
         check($sformatf("v%0d_memreq", i), bus.MemReq, 32'(vq[i].e_req));
         check($sformatf("v%0d_pcadvance", i), bus.PCAdvance, 32'(vq[i].e_adv));
         check($sformatf("v%0d_instrvalid", i), bus.InstrValid, 32'(vq[i].e_iv));
         if (vq[i].e_iv) begin
            check($sformatf("v%0d_instrout", i), bus.InstrOut, vq[i].e_iout);
            check($sformatf("v%0d_instrpc", i), bus.InstrPC, vq[i].e_ipc);
         end
         next_cycle();
      end

      // Full queue: decode stalled, 4 grants then MemReq low; one pop frees
      // exactly one slot, but not in the pop cycle itself.
      do_reset();
      begin
         int adv_cnt;
         adv_cnt = 0;
         exp_q = {};
         for (int k = 0; k < 6; k++) begin
            drive(1'b1, k >= 2, 32'hB000_0000 | 32'(k), 1'b0, 1'b0);
            if (k >= 2) exp_q.push_back({32'(4 * (k - 2)), 32'hB000_0000 | 32'(k)});
            @(negedge Clk);
            if (bus.PCAdvance) adv_cnt++;
            if (k >= 4) check($sformatf("full_memreq_low_%0d", k), bus.MemReq, 32'd0);
            next_cycle();
         end
         check("full_grant_count", 32'(adv_cnt), 32'd4);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge Clk);
      check("full_pop_memreq", bus.MemReq, 32'd0);
      check("full_pop_instrvalid", bus.InstrValid, 32'd1);
      e = exp_q.pop_front();
      check("full_pop_pc", bus.InstrPC, e[63:32]);
      check("full_pop_instr", bus.InstrOut, e[31:0]);
      next_cycle();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge Clk);
      check("refill_pcadvance", bus.PCAdvance, 32'd1);
      exp_q.push_back({32'h10, 32'hB000_0010});
      next_cycle();
      @(negedge Clk);
      check("refill_full_again", bus.MemReq, 32'd0);
      next_cycle();
      drive(1'b0, 1'b1, 32'hB000_0010, 1'b1, 1'b0);
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         @(negedge Clk);
         if (bus.InstrValid) begin
            e = exp_q.pop_front();
            check("drain_pc", bus.InstrPC, e[63:32]);
            check("drain_instr", bus.InstrOut, e[31:0]);
         end
         next_cycle();
         drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      end
      check("drain_all_popped", 32'(exp_q.size()), 32'd0);

      // Flush with three requests in flight: DRAIN until the third response.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         @(negedge Clk);
         check($sformatf("fl3_grant_%0d", k), bus.PCAdvance, 32'd1);
         next_cycle();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge Clk);
      check("fl3_flush_memreq", bus.MemReq, 32'd0);
      check("fl3_flush_pcadvance", bus.PCAdvance, 32'd0);
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, (k != 1) && (k != 4), 32'hDEAD_0000 | 32'(k), 1'b1, 1'b0);
         @(negedge Clk);
         check($sformatf("fl3_state_%0d", k), state_dbg, (k < 4) ? FQ_DRAIN : FQ_RUN);
         check($sformatf("fl3_memreq_%0d", k), bus.MemReq, (k < 4) ? 32'd0 : 32'd1);
         check($sformatf("fl3_instrvalid_%0d", k), bus.InstrValid, 32'd0);
         next_cycle();
      end

      // Flush coinciding with a response and an offered grant.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
         next_cycle();
      end
      drive(1'b1, 1'b1, 32'hC0DE_0000, 1'b1, 1'b1);
      @(negedge Clk);
      check("flrsp_pcadvance", bus.PCAdvance, 32'd0);
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge Clk);
      check("flrsp_instrvalid", bus.InstrValid, 32'd0);
      check("flrsp_state", state_dbg, FQ_DRAIN);
      next_cycle();
      drive(1'b0, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0);
      @(negedge Clk);
      check("flrsp_drain_memreq", bus.MemReq, 32'd0);
      next_cycle();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge Clk);
      check("flrsp_resume_grant", bus.PCAdvance, 32'd1);
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 1'b1, 32'hC0DE_0001, 1'b1, 1'b0);
      @(negedge Clk);
      check("flrsp_fill_cycle_invalid", bus.InstrValid, 32'd0);
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge Clk);
      check("flrsp_recover_valid", bus.InstrValid, 32'd1);
      check("flrsp_recover_pc", bus.InstrPC, 32'h8);
      check("flrsp_recover_instr", bus.InstrOut, 32'hC0DE_0001);
      next_cycle();

      // Flush inside DRAIN keeps the count, then Reset mid-DRAIN.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         next_cycle();
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      next_cycle();
      drive(1'b0, 1'b1, 32'hDEAD_0002, 1'b0, 1'b1);
      @(negedge Clk);
      check("rstdr_state_a", state_dbg, FQ_DRAIN);
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge Clk);
      check("rstdr_state_b", state_dbg, FQ_DRAIN);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      Reset = 1'b1;
      #1;
      check("rstdr_async_state", state_dbg, FQ_RUN);
      check("rstdr_async_memreq", bus.MemReq, 32'd0);
      check("rstdr_async_pcadvance", bus.PCAdvance, 32'd0);
      check("rstdr_async_instrvalid", bus.InstrValid, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("rstdr_release_state", state_dbg, FQ_RUN);
      check("rstdr_release_memreq", bus.MemReq, 32'd1);
      check("rstdr_release_instrvalid", bus.InstrValid, 32'd0);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2 to 16.
REQ-002 Clk  in  1  sole clock; all state updates on posedge Clk.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 PCResult  in  32  current fetch address from the program counter register.
REQ-005 PCAdvance  out  1  high for one cycle when PCResult is accepted; upstream next-PC logic loads the next address on this.
REQ-006 MemAddr  out  32  instruction memory request address; equals PCResult.
REQ-007 MemReq  out  1  request valid.
REQ-008 MemGnt  in  1  memory accepts the request when MemReq and MemGnt are both high.
REQ-009 MemRdata  in  32  instruction word returned by memory.
REQ-010 MemRvalid  in  1  response valid; exactly one per granted request, in order, at least 1 cycle after grant.
REQ-011 Flush  in  1  redirect; discard all queued and in-flight fetches.
REQ-012 InstrOut  out  32  head instruction word to decode.
REQ-013 InstrPC  out  32  address of InstrOut.
REQ-014 InstrValid  out  1  head entry holds a returned instruction.
REQ-015 InstrReady  in  1  decode consumes the head when InstrValid and InstrReady are both high.

Function
REQ-016 The queue shall keep three pointers (head, fill, tail) of log2(DEPTH)+1 bits; the MSB distinguishes full from empty and the pointers wrap modulo 2*DEPTH.
REQ-017 Occupancy (tail-head) shall count allocated entries, both awaiting-response and filled.
REQ-018 MemReq shall be combinational: state RUN, occupancy < DEPTH, Flush low, Reset low.
REQ-019 On grant, the block shall write PCResult into entry[tail], increment tail, and assert PCAdvance in the same cycle; PCAdvance = MemReq & MemGnt.
REQ-020 On MemRvalid in RUN, the block shall write MemRdata into entry[fill] and increment fill.
REQ-021 InstrValid shall be high iff fill != head; InstrOut and InstrPC shall come from entry[head]; a handshake shall increment head.
REQ-022 Grant, response and pop in the same cycle shall all take effect; a full queue shall not accept a grant even if a pop occurs that cycle.
REQ-023 Latency: a response returned in cycle N shall appear on InstrOut with InstrValid high in cycle N+1.
REQ-024 FSM states: RUN and DRAIN.
REQ-025 On Flush, head, fill and tail shall be set equal, and the discard counter shall load the number of in-flight requests (tail-fill), minus 1 if MemRvalid is high that cycle.
REQ-026 On Flush, the FSM shall enter DRAIN if the loaded count is nonzero; otherwise it shall stay in RUN.
REQ-027 In DRAIN, MemReq shall be low, each MemRvalid shall be discarded and decrement the counter, and the FSM shall return to RUN when the counter reaches 0.
REQ-028 A response arriving in a Flush cycle shall be discarded.
REQ-029 InstrValid shall be low in the cycle after Flush.
REQ-030 Flush while in DRAIN shall leave the count unchanged apart from a same-cycle decrement.
REQ-031 MemRvalid with no request outstanding is a protocol error; the block shall ignore it and shall not move any pointer.

Reset
REQ-032 While Reset is high, all pointers and the discard counter shall be 0, state shall be RUN, and MemReq, PCAdvance and InstrValid shall be 0.
REQ-033 Reset asserted mid-operation shall drop all entries without draining; responses to requests issued before Reset are the memory's responsibility.
REQ-034 Entry data shall not be reset.

Structure
REQ-035 The FSM state encoding (RUN, DRAIN) and the DEPTH default shall live in the shared pipeline package.
REQ-036 Entry storage shall be one sub-module, fetch_queue_ram: DEPTH x 64 bits, one write port for the PC half, one write port for the data half, and one asynchronous read port.

Verification
REQ-037 Reset, PCResult=0x0, MemGnt=1, response 2 cycles after grant -> PCAdvance each cycle; InstrPC 0x0, 0x4, 0x8 in order with matching InstrOut.
REQ-038 InstrReady=0, DEPTH=4 -> exactly 4 grants, then MemReq low; one pop -> exactly one further grant.
REQ-039 Flush with 3 requests in flight -> DRAIN; 3 responses discarded; MemReq high only in the cycle after the third response.
REQ-040 Flush in the same cycle as MemRvalid and grant -> that response discarded, no PCAdvance, InstrValid low next cycle.
REQ-041 Single-entry queue: response and pop in the same cycle -> no bubble, and InstrValid stays high.
REQ-042 Reset asserted during DRAIN -> outputs at reset values immediately (asynchronous), and state is RUN after release.
